lcd_time_display: RTL and testbench

//  Consumer of the time-keeping block's BCD digits (hour_10..sec1) and daynight flag.

---
 rtl/lcd_time_display_if.sv | 26 ++
 rtl/lcd_time_display.sv | 183 ++++++++++++++++++
 tb/tb_lcd_time_display.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_time_display_if.sv
// Bundle between the time-keeping block, the LCD controller and the LCD pins.
// master = controller side (consumes digits, drives the LCD bus); slave = the other side.
interface lcd_time_display_if;
   logic [3:0] hour_10;
   logic [3:0] hour1;
   logic [3:0] min_10;
   logic [3:0] min1;
   logic [3:0] sec_10;
   logic [3:0] sec1;
   logic       daynight;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;
   logic       frame_done;

   modport master (
      input  hour_10, hour1, min_10, min1, sec_10, sec1, daynight,
      output lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
   );

   modport slave (
      output hour_10, hour1, min_10, min1, sec_10, sec1, daynight,
      input  lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
   );
endinterface

// File: rtl/lcd_time_display.sv
// HD44780 16x2 driver: init sequence after reset, then endless refresh of
// "TIME HH:MM:SS" / "MODE: DAY|NIGHT" from a per-frame snapshot of the inputs.
//
// state          | meaning
// ---------------+------------------------------------------------
// S_INIT_WAIT    | power-up idle, outputs quiet, INIT_CYC cycles
// S_FUNC_SET     | command 0x38 (8-bit bus, 2 lines)
// S_DISP_ON      | command 0x0C (display on, no cursor)
// S_ENTRY        | command 0x06 (auto-increment)
// S_CLEAR        | command 0x01, long slot of CLEAR_CYC cycles
// S_LINE1_ADDR   | command 0x80, inputs snapshotted in its first cycle
// S_LINE1_CHARS  | 16 character writes for line 1
// S_LINE2_ADDR   | command 0xC0
// S_LINE2_CHARS  | 16 character writes for line 2, then back to line 1
module lcd_time_display #(
   parameter int INIT_CYC  = 20000,
   parameter int STEP_CYC  = 50,
   parameter int E_CYC     = 20,
   parameter int CLEAR_CYC = 2000
) (
   input  logic               clk,
   input  logic               rst,
   lcd_time_display_if.master bus
);

   localparam int MAX_A   = (INIT_CYC > CLEAR_CYC) ? INIT_CYC : CLEAR_CYC;
   localparam int MAX_CYC = (MAX_A > STEP_CYC) ? MAX_A : STEP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int EC_W    = $clog2(E_CYC + 1);

   localparam logic [3:0] S_INIT_WAIT   = 4'd0;
   localparam logic [3:0] S_FUNC_SET    = 4'd1;
   localparam logic [3:0] S_DISP_ON     = 4'd2;
   localparam logic [3:0] S_ENTRY       = 4'd3;
   localparam logic [3:0] S_CLEAR       = 4'd4;
   localparam logic [3:0] S_LINE1_ADDR  = 4'd5;
   localparam logic [3:0] S_LINE1_CHARS = 4'd6;
   localparam logic [3:0] S_LINE2_ADDR  = 4'd7;
   localparam logic [3:0] S_LINE2_CHARS = 4'd8;

   localparam logic [127:0] LINE1_TXT   = "TIME   :  :     ";
   localparam logic [127:0] LINE2_DAY   = "MODE: DAY       ";
   localparam logic [127:0] LINE2_NIGHT = "MODE: NIGHT     ";

   logic [3:0]       state;
   logic [3:0]       next_state;
   logic [3:0]       char_idx;
   logic [3:0]       next_idx;
   logic [CNT_W-1:0] slot_cnt;
   logic [EC_W-1:0]  e_cnt;
   logic [23:0]      snap_time;
   logic             snap_dn;
   logic             lcd_e_q;
   logic             lcd_rs_q;
   logic [7:0]       lcd_data_q;
   logic             frame_done_q;
   logic [7:0]       line1_byte;
   logic [7:0]       line2_byte;
   logic [7:0]       next_byte;
   logic             next_rs;
   logic [CNT_W-1:0] next_len_m1;
   logic             slot_end;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
   endfunction

   assign slot_end = (slot_cnt == '0);

   always_comb begin
      next_state = state;
      next_idx   = char_idx;
      case (state)
         S_INIT_WAIT:  next_state = S_FUNC_SET;
         S_FUNC_SET:   next_state = S_DISP_ON;
         S_DISP_ON:    next_state = S_ENTRY;
         S_ENTRY:      next_state = S_CLEAR;
         S_CLEAR:      next_state = S_LINE1_ADDR;
         S_LINE1_ADDR: begin
            next_state = S_LINE1_CHARS;
            next_idx   = 4'd0;
         end
         S_LINE1_CHARS: begin
            if (char_idx == 4'd15) next_state = S_LINE2_ADDR;
            else                   next_idx   = char_idx + 4'd1;
         end
         S_LINE2_ADDR: begin
            next_state = S_LINE2_CHARS;
            next_idx   = 4'd0;
         end
         S_LINE2_CHARS: begin
            if (char_idx == 4'd15) next_state = S_LINE1_ADDR;
            else                   next_idx   = char_idx + 4'd1;
         end
         default:      next_state = S_INIT_WAIT;
      endcase
   end

   // Text bytes come from the snapshot, never the live inputs, so a frame cannot tear.
   always_comb begin
      line1_byte = LINE1_TXT[{~next_idx, 3'b000} +: 8];
      case (next_idx)
         4'd5:    line1_byte = digit_char(snap_time[23:20]);
         4'd6:    line1_byte = digit_char(snap_time[19:16]);
         4'd8:    line1_byte = digit_char(snap_time[15:12]);
         4'd9:    line1_byte = digit_char(snap_time[11:8]);
         4'd11:   line1_byte = digit_char(snap_time[7:4]);
         4'd12:   line1_byte = digit_char(snap_time[3:0]);
         default: ;
      endcase
      line2_byte = snap_dn ? LINE2_DAY[{~next_idx, 3'b000} +: 8]
                           : LINE2_NIGHT[{~next_idx, 3'b000} +: 8];
   end

   always_comb begin
      next_rs   = 1'b0;
      next_byte = 8'h00;
      case (next_state)
         S_FUNC_SET:    next_byte = 8'h38;
         S_DISP_ON:     next_byte = 8'h0C;
         S_ENTRY:       next_byte = 8'h06;
         S_CLEAR:       next_byte = 8'h01;
         S_LINE1_ADDR:  next_byte = 8'h80;
         S_LINE1_CHARS: begin
            next_byte = line1_byte;
            next_rs   = 1'b1;
         end
         S_LINE2_ADDR:  next_byte = 8'hC0;
         S_LINE2_CHARS: begin
            next_byte = line2_byte;
            next_rs   = 1'b1;
         end
         default:       next_byte = 8'h00;
      endcase
      next_len_m1 = (next_state == S_CLEAR) ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(STEP_CYC - 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_INIT_WAIT;
         char_idx     <= 4'd0;
         slot_cnt     <= CNT_W'(INIT_CYC - 1);
         e_cnt        <= '0;
         lcd_e_q      <= 1'b0;
         lcd_rs_q     <= 1'b0;
         lcd_data_q   <= 8'h00;
         frame_done_q <= 1'b0;
         snap_time    <= 24'h0;
         snap_dn      <= 1'b0;
      end else begin
         frame_done_q <= (state == S_LINE2_CHARS) && (char_idx == 4'd15) &&
                         (slot_cnt == CNT_W'(1));
         if (slot_end) begin
            state      <= next_state;
            char_idx   <= next_idx;
            slot_cnt   <= next_len_m1;
            e_cnt      <= EC_W'(E_CYC);
            lcd_e_q    <= 1'b0;
            lcd_data_q <= next_byte;
            lcd_rs_q   <= next_rs;
         end else begin
            slot_cnt <= slot_cnt - CNT_W'(1);
            if (e_cnt != '0) begin
               lcd_e_q <= 1'b1;
               e_cnt   <= e_cnt - EC_W'(1);
            end else begin
               lcd_e_q <= 1'b0;
            end
         end
         if ((state == S_LINE1_ADDR) && (slot_cnt == CNT_W'(STEP_CYC - 1))) begin
            snap_time <= {bus.hour_10, bus.hour1, bus.min_10, bus.min1, bus.sec_10, bus.sec1};
            snap_dn   <= bus.daynight;
         end
      end
   end

   assign bus.lcd_e      = lcd_e_q;
   assign bus.lcd_rs     = lcd_rs_q;
   assign bus.lcd_rw     = 1'b0;
   assign bus.lcd_data   = lcd_data_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_time_display.sv
// Bench for lcd_time_display: decodes every lcd_e strobe and compares the byte
// stream, slot timing and frame_done against a string-level model of the display.
module tb_lcd_time_display;
   localparam int INIT_CYC  = 20;
   localparam int STEP_CYC  = 8;
   localparam int E_CYC     = 3;
   localparam int CLEAR_CYC = 40;
   localparam int FRAME_CYC = 34 * STEP_CYC;

   logic clk = 1'b0;
   logic rst;
   lcd_time_display_if bus ();

   lcd_time_display #(
      .INIT_CYC (INIT_CYC),
      .STEP_CYC (STEP_CYC),
      .E_CYC    (E_CYC),
      .CLEAR_CYC(CLEAR_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int last_cyc = 0;
   int first_frame_last = 0;
   int frames_checked = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] q_data[$];
   logic       q_rs[$];
   int         q_cyc[$];
   int         fd_cyc[$];
   logic       e_prev = 1'b0;
   int         e_width = 0;
   logic [7:0] rise_d = 8'h00;
   logic       rise_rs = 1'b0;

   // Strobe monitor: records each rising lcd_e and checks width and bus stability.
   always @(negedge clk) begin
      if (rst) begin
         e_prev  = 1'b0;
         e_width = 0;
      end else begin
         if (bus.lcd_e && !e_prev) begin
            q_data.push_back(bus.lcd_data);
            q_rs.push_back(bus.lcd_rs);
            q_cyc.push_back(cyc);
            rise_d  = bus.lcd_data;
            rise_rs = bus.lcd_rs;
            e_width = 1;
         end else if (bus.lcd_e) begin
            e_width++;
         end else if (e_prev) begin
            tests++;
            if (e_width != E_CYC || bus.lcd_data !== rise_d || bus.lcd_rs !== rise_rs ||
                bus.lcd_rw !== 1'b0) begin
               fails++;
               $display("FAIL e_pulse: width %0d data %h rs %b rw %b, required width %0d data %h rs %b rw 0",
                        e_width, bus.lcd_data, bus.lcd_rs, bus.lcd_rw, E_CYC, rise_d, rise_rs);
            end
         end
         if (bus.frame_done === 1'b1) fd_cyc.push_back(cyc);
         e_prev = bus.lcd_e;
      end
   end

   typedef struct {
      logic [23:0]  digits;
      logic         dn;
      logic [127:0] l1;
      logic [127:0] l2;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [7:0] asc(input logic [3:0] d);
      return (d < 4'd10) ? (8'h30 + 8'(d)) : 8'h3F;
   endfunction

   function automatic logic [127:0] model_l1(input logic [23:0] g);
      return {"TIME ", asc(g[23:20]), asc(g[19:16]), ":", asc(g[15:12]), asc(g[11:8]), ":",
              asc(g[7:4]), asc(g[3:0]), "   "};
   endfunction

   function automatic logic [127:0] model_l2(input logic dn);
      logic [127:0] day;
      logic [127:0] night;
      day   = "MODE: DAY       ";
      night = "MODE: NIGHT     ";
      return dn ? day : night;
   endfunction

   function automatic logic [3:0] rand_digit();
      if ($urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
      return 4'($urandom_range(0, 9));
   endfunction

   task automatic apply(input logic [23:0] g, input logic dn);
      {bus.hour_10, bus.hour1, bus.min_10, bus.min1, bus.sec_10, bus.sec1} = g;
      bus.daynight = dn;
   endtask

   task automatic pop_rise(output logic [7:0] d, output logic r, output int c);
      int t = 0;
      while (q_data.size() == 0 && t < 4 * CLEAR_CYC) begin
         @(posedge clk);
         t++;
      end
      if (q_data.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: no lcd_e rise within %0d cycles, required one", t);
         d = 8'h00;
         r = 1'b0;
         c = -1;
      end else begin
         d = q_data.pop_front();
         r = q_rs.pop_front();
         c = q_cyc.pop_front();
      end
   endtask

   task automatic check_init(input int rel);
      logic [7:0] cmds[4];
      logic [7:0] d;
      logic       r;
      int         c;
      int         exp_c;
      cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
      for (int i = 0; i < 4; i++) begin
         pop_rise(d, r, c);
         exp_c = (i == 0) ? rel + INIT_CYC + 1 : last_cyc + STEP_CYC;
         tests++;
         if (d !== cmds[i] || r !== 1'b0 || c != exp_c) begin
            fails++;
            $display("FAIL init_cmd%0d: data %h rs %b at cycle %0d, required data %h rs 0 at cycle %0d",
                     i, d, r, c, cmds[i], exp_c);
         end
         last_cyc = c;
      end
   endtask

   task automatic check_frame(input logic [127:0] l1, input logic [127:0] l2, input int first_gap,
                              input int mid_sec1, input string name);
      logic [7:0] d, exp_d, bad_d, bad_exp_d;
      logic       r, exp_r, bad_r, bad_exp_r;
      int         c, gap, exp_gap, bad_k, bad_gap, bad_exp_gap, errs;
      errs = 0;
      bad_k = -1;
      bad_d = 0; bad_exp_d = 0; bad_r = 0; bad_exp_r = 0; bad_gap = 0; bad_exp_gap = 0;
      for (int k = 0; k < 34; k++) begin
         pop_rise(d, r, c);
         if (k == 0) begin
            exp_d = 8'h80; exp_r = 1'b0;
         end else if (k <= 16) begin
            exp_d = l1[(16 - k) * 8 +: 8]; exp_r = 1'b1;
         end else if (k == 17) begin
            exp_d = 8'hC0; exp_r = 1'b0;
         end else begin
            exp_d = l2[(33 - k) * 8 +: 8]; exp_r = 1'b1;
         end
         exp_gap = (k == 0) ? first_gap : STEP_CYC;
         gap = c - last_cyc;
         if (d !== exp_d || r !== exp_r || gap != exp_gap) begin
            if (errs == 0) begin
               bad_k = k; bad_d = d; bad_exp_d = exp_d; bad_r = r; bad_exp_r = exp_r;
               bad_gap = gap; bad_exp_gap = exp_gap;
            end
            errs++;
         end
         last_cyc = c;
         if (k == 4 && mid_sec1 >= 0) begin
            @(negedge clk);
            bus.sec1 = mid_sec1[3:0];
         end
      end
      frames_checked++;
      tests++;
      if (errs != 0) begin
         fails++;
         $display("FAIL frame_%s: slot %0d got rs=%b data=%h gap %0d, required rs=%b data=%h gap %0d (%0d bad slots)",
                  name, bad_k, bad_r, bad_d, bad_gap, bad_exp_r, bad_exp_d, bad_exp_gap, errs);
      end
   endtask

   task automatic check_quiet(input string name);
      tests++;
      if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.frame_done} !== 12'h000) begin
         fails++;
         $display("FAIL %s: e=%b rs=%b rw=%b data=%h frame_done=%b, required all 0",
                  name, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.frame_done);
      end
   endtask

   initial begin
      logic [23:0] g;
      logic        dn;
      logic [7:0]  d;
      logic        r;
      int          c;
      int          rel;
      int          bad_diffs;

      vecs[0] = '{24'h123456, 1'b0, "TIME 12:34:56   ", "MODE: NIGHT     "};
      vecs[1] = '{24'h123A56, 1'b1, "TIME 12:3?:56   ", "MODE: DAY       "};
      vecs[2] = '{24'h235959, 1'b1, "TIME 23:59:59   ", "MODE: DAY       "};
      vecs[3] = '{24'hFB0C9D, 1'b0, "TIME ??:0?:9?   ", "MODE: NIGHT     "};
      vecs[4] = '{24'h000000, 1'b1, "TIME 00:00:00   ", "MODE: DAY       "};

      rst = 1'b1;
      apply(24'h123456, 1'b1);
      repeat (3) @(negedge clk);
      #1 check_quiet("reset_outputs");
      @(negedge clk);
      rst = 1'b0;
      rel = cyc;

      check_init(rel);
      check_frame("TIME 12:34:56   ", "MODE: DAY       ", CLEAR_CYC, -1, "first");
      first_frame_last = last_cyc;

      for (int i = 0; i < 5; i++) begin
         apply(vecs[i].digits, vecs[i].dn);
         check_frame(vecs[i].l1, vecs[i].l2, STEP_CYC, -1, $sformatf("vec%0d", i));
      end

      apply(24'h123455, 1'b1);
      check_frame(model_l1(24'h123455), model_l2(1'b1), STEP_CYC, 9, "snap_current");
      check_frame(model_l1(24'h123459), model_l2(1'b1), STEP_CYC, -1, "snap_next");

      for (int i = 0; i < 8; i++) begin
         g  = {rand_digit(), rand_digit(), rand_digit(), rand_digit(), rand_digit(), rand_digit()};
         dn = 1'($urandom_range(0, 1));
         apply(g, dn);
         check_frame(model_l1(g), model_l2(dn), STEP_CYC, -1, $sformatf("rand%0d_%h_%b", i, g, dn));
      end

      repeat (STEP_CYC) @(posedge clk);
      tests++;
      if (fd_cyc.size() != frames_checked) begin
         fails++;
         $display("FAIL frame_done_count: %0d pulses, required %0d", fd_cyc.size(), frames_checked);
      end
      tests++;
      if (fd_cyc.size() == 0 || fd_cyc[0] != first_frame_last + STEP_CYC - 2) begin
         fails++;
         $display("FAIL frame_done_position: first pulse at cycle %0d, required %0d",
                  (fd_cyc.size() == 0) ? -1 : fd_cyc[0], first_frame_last + STEP_CYC - 2);
      end
      bad_diffs = 0;
      for (int i = 1; i < fd_cyc.size(); i++)
         if (fd_cyc[i] - fd_cyc[i-1] != FRAME_CYC) bad_diffs++;
      tests++;
      if (bad_diffs != 0) begin
         fails++;
         $display("FAIL frame_done_period: %0d spacings differ, required all %0d cycles",
                  bad_diffs, FRAME_CYC);
      end

      apply(vecs[0].digits, vecs[0].dn);
      for (int k = 0; k < 20; k++) pop_rise(d, r, c);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_quiet("reset_async");
      repeat (3) @(negedge clk);
      q_data.delete();
      q_rs.delete();
      q_cyc.delete();
      fd_cyc.delete();
      rst = 1'b0;
      rel = cyc;
      check_init(rel);
      check_frame(vecs[0].l1, vecs[0].l2, CLEAR_CYC, -1, "after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
